// File: rtl/keypad_emitter.sv
// Keypad emulator: buffers BCD digits in a small FIFO and replays each one as a
// timed key press on the a..g column/row lines, separated by an all-low gap.
module keypad_emitter #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int DEPTH       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [3:0] in_digit,
    output logic       in_ready,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       busy,
    output logic       err
);
    localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC);
    localparam int PW   = $clog2(DEPTH);

    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   OCC_ONE  = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PRESS   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [3:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [6:0]    lines_q, lines_d;
    logic          rdy_q;
    logic          err_q;
    logic          full, accept, push, pop;

    // Line order is {a,b,c,d,e,f,g}: three columns then four rows.
    function automatic logic [6:0] key_lines(input logic [3:0] dgt);
        logic [6:0] pat;
        case (dgt)
            4'd1:    pat = 7'b100_1000;
            4'd2:    pat = 7'b010_1000;
            4'd3:    pat = 7'b001_1000;
            4'd4:    pat = 7'b100_0100;
            4'd5:    pat = 7'b010_0100;
            4'd6:    pat = 7'b001_0100;
            4'd7:    pat = 7'b100_0010;
            4'd8:    pat = 7'b010_0010;
            4'd9:    pat = 7'b001_0010;
            4'd0:    pat = 7'b010_0001;
            default: pat = 7'b000_0000;
        endcase
        return pat;
    endfunction

    // rdy_q keeps in_ready low until the first edge after reset release.
    always_comb begin
        full     = (count_q == FULL_CNT);
        in_ready = rdy_q && !full;
        accept   = in_valid && in_ready;
        push     = accept && (in_digit <= 4'd9);
        busy     = (state_q != IDLE) || (count_q != '0);
        err      = err_q;
        {a, b, c, d, e, f, g} = lines_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lines_d = lines_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                lines_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    lines_d = key_lines(mem_q[rd_ptr_q]);
                    cnt_d   = HOLD_LD;
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (cnt_q == '0) begin
                    lines_d = '0;
                    cnt_d   = GAP_LD;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            RELEASE: begin
                lines_d = '0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (count_q != '0) begin
                    pop     = 1'b1;
                    lines_d = key_lines(mem_q[rd_ptr_q]);
                    cnt_d   = HOLD_LD;
                    state_d = PRESS;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                lines_d = '0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            lines_q  <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lines_q <= lines_d;
            rdy_q   <= 1'b1;
            err_q   <= accept && (in_digit > 4'd9);
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + OCC_ONE;
                2'b01:   count_q <= count_q - OCC_ONE;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= in_digit;
    end

endmodule
